// File: rtl/keypad_scanner_adv_pkg.sv
// Shared definitions for the 4x4 keypad scanner: bus window, register word
// layout, key codes and the scan FSM state type.
package keypad_scanner_adv_pkg;

   typedef logic [31:0] base_addr_type;
   typedef logic [31:0] addr_mask_type;

   localparam base_addr_type CFG_BADR_Keypad = 32'h0000_1000;
   localparam addr_mask_type CFG_MADR_Keypad = 32'hFFFF_FFF0;

   localparam int N_WORDS = 3;
   localparam int STATUS  = 0;
   localparam int KEYMAP  = 1;
   localparam int CONTROL = 2;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_IRQ_EN = 8;
   localparam int CTRL_CLEAR  = 16;
   localparam int CTRL_POP    = 24;

   localparam int STAT_VALID    = 4;
   localparam int STAT_OVERFLOW = 16;

   typedef logic [3:0] key_code_t;

   typedef enum logic [2:0] {
      SCAN_IDLE,
      SCAN_SAMPLE,
      SCAN_UPD0,
      SCAN_UPD1,
      SCAN_UPD2,
      SCAN_UPD3
   } scan_state_t;

   function automatic key_code_t key_index(input logic [1:0] row, input logic [1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/keypad_scanner_adv_if.sv
// Simple single-cycle request / registered-response SoC data bus.
interface DATA_BUS;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        wr;
   logic        rd;
   logic        ack;

   modport Master (output addr, wdata, wr, rd, input rdata, ack);
   modport Slave  (input addr, wdata, wr, rd, output rdata, ack);
endinterface

// File: rtl/db_reg_intf.sv
// Bank of N_WORDS bus-visible 32-bit registers; the block refreshes them via
// new_data_i, while a same-cycle bus write keeps priority for its own word.
module db_reg_intf
   import keypad_scanner_adv_pkg::*;
#(
   parameter int                         N_WORDS   = 3,
   parameter base_addr_type              base_addr = CFG_BADR_Keypad,
   parameter addr_mask_type              addr_mask = CFG_MADR_Keypad,
   parameter logic [N_WORDS-1:0][31:0]   reg_init  = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   DATA_BUS.Slave                      dslv,
   output logic [N_WORDS-1:0][31:0]    reg_data_o,
   input  logic [N_WORDS-1:0][31:0]    reg_data_i,
   input  logic                        new_data_i
);

   localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

   logic [N_WORDS-1:0][31:0] regs;
   logic                     hit;
   logic [IW-1:0]            word_idx;
   logic                     idx_ok;

   assign hit        = ((dslv.addr & addr_mask) == (base_addr & addr_mask));
   assign word_idx   = dslv.addr[2 +: IW];
   assign idx_ok     = (int'(word_idx) < N_WORDS);
   assign reg_data_o = regs;

   always_ff @(posedge clk) begin
      if (rst) begin
         regs       <= reg_init;
         dslv.ack   <= 1'b0;
         dslv.rdata <= '0;
      end else begin
         dslv.ack   <= hit && (dslv.wr || dslv.rd);
         dslv.rdata <= (hit && dslv.rd && idx_ok) ? regs[word_idx] : '0;
         for (int i = 0; i < N_WORDS; i++) begin
            if (hit && dslv.wr && (int'(word_idx) == i)) begin
               regs[i] <= dslv.wdata;
            end else if (new_data_i) begin
               regs[i] <= reg_data_i[i];
            end
         end
      end
   end

endmodule

// File: rtl/keypad_scanner_adv_key_fifo.sv
// Key-code queue with flush; a push into a full queue is accepted only when a
// pop frees a slot in the same cycle.
module key_fifo
   import keypad_scanner_adv_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  key_code_t                  din,
   output key_code_t                  dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   key_code_t     mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/simple_timer.sv
// Free-running period counter emitting a one-cycle overflow pulse every PERIOD cycles.
module simple_timer #(
   parameter int unsigned PERIOD = 10
) (
   input  logic clk,
   input  logic rst,
   output logic ovf
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [CW-1:0] cnt;

   assign ovf = (cnt == CW'(PERIOD - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (ovf) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/keypad_scanner_adv.sv
// Memory-mapped 4x4 keypad reader: row-by-row scan, per-key debounce and a
// queue of press codes popped by software through the control word.
module keypad_scanner_adv
   import keypad_scanner_adv_pkg::*;
#(
   parameter base_addr_type base_addr      = CFG_BADR_Keypad,
   parameter addr_mask_type addr_mask      = CFG_MADR_Keypad,
   parameter real           CLK_FREQ       = 100.0,
   parameter real           SCAN_RATE      = 1000.0,
   parameter int            DEBOUNCE_SCANS = 4,
   parameter int            FIFO_DEPTH     = 8
) (
   input  logic       clk,
   input  logic       rst,
   DATA_BUS.Slave     dslv,
   output logic [3:0] rows,
   input  logic [3:0] cols,
   output logic       irq
);

   localparam int          ROW_PERIOD    = int'(CLK_FREQ * 1.0e6 / (SCAN_RATE * 4.0));
   localparam int          CW            = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] CTRL_STROBES  = (32'd1 << CTRL_POP) | (32'd1 << CTRL_CLEAR);

   logic [N_WORDS-1:0][31:0] reg_data_o;
   logic [N_WORDS-1:0][31:0] reg_data_i;
   logic                     new_data_i;

   logic enable, irq_en, pop_req, clear_req;
   logic row_tick;

   scan_state_t state, state_next;
   logic [1:0]  row_idx;
   logic [1:0]  sample_row;
   logic [3:0]  sample;
   logic [15:0] key_map;
   logic [3:0]  deb_cnt [16];

   logic        upd_en;
   logic [1:0]  upd_col;
   key_code_t   upd_idx;
   logic        upd_raw;
   logic [3:0]  cnt_inc;
   logic        upd_flip;
   logic        key_push;

   key_code_t   head_code;
   logic [CW-1:0] fifo_count;
   logic        fifo_full, fifo_empty;
   logic        overflow;
   logic [31:0] status_word;
   logic [31:0] keymap_word;

   assign enable    = reg_data_o[CONTROL][CTRL_ENABLE];
   assign irq_en    = reg_data_o[CONTROL][CTRL_IRQ_EN];
   assign pop_req   = reg_data_o[CONTROL][CTRL_POP];
   assign clear_req = reg_data_o[CONTROL][CTRL_CLEAR];

   db_reg_intf #(
      .N_WORDS   (N_WORDS),
      .base_addr (base_addr),
      .addr_mask (addr_mask),
      .reg_init  ('0)
   ) u_regs (
      .clk        (clk),
      .rst        (rst),
      .dslv       (dslv),
      .reg_data_o (reg_data_o),
      .reg_data_i (reg_data_i),
      .new_data_i (new_data_i)
   );

   simple_timer #(
      .PERIOD (ROW_PERIOD)
   ) u_timer (
      .clk (clk),
      .rst (rst | ~enable),
      .ovf (row_tick)
   );

   assign rows = enable ? ~(4'b0001 << row_idx) : 4'b1111;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SCAN_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Each UPDk state debounces one column of the row latched in SAMPLE, so at
   // most one code is pushed per cycle and same-row presses queue by column.
   always_comb begin
      state_next = state;
      upd_en     = 1'b0;
      upd_col    = 2'd0;
      case (state)
         SCAN_IDLE:   if (row_tick) state_next = SCAN_SAMPLE;
         SCAN_SAMPLE: state_next = SCAN_UPD0;
         SCAN_UPD0: begin
            upd_en     = 1'b1;
            upd_col    = 2'd0;
            state_next = SCAN_UPD1;
         end
         SCAN_UPD1: begin
            upd_en     = 1'b1;
            upd_col    = 2'd1;
            state_next = SCAN_UPD2;
         end
         SCAN_UPD2: begin
            upd_en     = 1'b1;
            upd_col    = 2'd2;
            state_next = SCAN_UPD3;
         end
         SCAN_UPD3: begin
            upd_en     = 1'b1;
            upd_col    = 2'd3;
            state_next = SCAN_IDLE;
         end
         default:     state_next = SCAN_IDLE;
      endcase
      if (!enable) begin
         state_next = SCAN_IDLE;
         upd_en     = 1'b0;
      end
      upd_idx  = key_index(sample_row, upd_col);
      upd_raw  = sample[upd_col];
      cnt_inc  = deb_cnt[upd_idx] + 4'd1;
      upd_flip = upd_en && (upd_raw != key_map[upd_idx]) && (cnt_inc == 4'(DEBOUNCE_SCANS));
      key_push = upd_flip && upd_raw;
   end

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         row_idx    <= 2'd0;
         sample_row <= 2'd0;
         sample     <= 4'd0;
         key_map    <= 16'd0;
         for (int i = 0; i < 16; i++) begin
            deb_cnt[i] <= 4'd0;
         end
      end else begin
         if (state == SCAN_SAMPLE) begin
            sample     <= ~cols;
            sample_row <= row_idx;
            row_idx    <= row_idx + 2'd1;
         end
         if (upd_en) begin
            if (upd_raw == key_map[upd_idx]) begin
               deb_cnt[upd_idx] <= 4'd0;
            end else if (upd_flip) begin
               key_map[upd_idx] <= upd_raw;
               deb_cnt[upd_idx] <= 4'd0;
            end else begin
               deb_cnt[upd_idx] <= cnt_inc;
            end
         end
      end
   end

   key_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (key_push),
      .pop   (pop_req),
      .clear (clear_req),
      .din   (upd_idx),
      .dout  (head_code),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (clear_req) begin
            overflow <= 1'b0;
         end else if (key_push && fifo_full && !pop_req) begin
            overflow <= 1'b1;
         end
         irq <= irq_en && !fifo_empty;
      end
   end

   // Register image; control is echoed back with its strobes cleared so that
   // pop and clear act for exactly one cycle.
   always_comb begin
      status_word                = '0;
      status_word[3:0]           = fifo_empty ? 4'd0 : head_code;
      status_word[STAT_VALID]    = !fifo_empty;
      status_word[11:8]          = 4'(fifo_count);
      status_word[STAT_OVERFLOW] = overflow;
      keymap_word                = {16'd0, key_map};
      reg_data_i                 = '0;
      reg_data_i[STATUS]         = status_word;
      reg_data_i[KEYMAP]         = keymap_word;
      reg_data_i[CONTROL]        = reg_data_o[CONTROL] & ~CTRL_STROBES;
      new_data_i = (status_word != reg_data_o[STATUS]) ||
                   (keymap_word != reg_data_o[KEYMAP]) ||
                   pop_req || clear_req;
   end

endmodule

// File: doc/keypad_scanner_adv.md
# keypad_scanner_adv

Memory-mapped 4x4 matrix keypad reader on the SoC data bus, the input-side counterpart of the seven-segment display peripheral. It drives one row low at a time, samples the four columns, debounces every key, and queues press events as 4-bit key codes in a small FIFO. Software pops codes through a command-style control register. An optional level interrupt signals a non-empty queue.

## Interface
- base_addr, CFG_BADR_Keypad, bus base address (base_addr_type)
- addr_mask, CFG_MADR_Keypad, bus address mask (addr_mask_type)
- CLK_FREQ, 100, clock frequency in MHz (real)
- SCAN_RATE, 1000, full-matrix scans per second in Hz (real)
- DEBOUNCE_SCANS, 4, consecutive equal samples required to change a key's state (2..15)
- FIFO_DEPTH, 8, key-code queue depth (power of two, max 15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dslv  DATA_BUS.Slave  -  bus slave port, served through db_reg_intf with N_WORDS=3 and reg_init '0
- rows  out  4  row drive, active low, exactly one row low while scanning
- cols  in  4  column sense, active low (external pull-ups)
- irq  out  1  registered, high while irq_en=1 and the FIFO is non-empty

## Operation
- Word 0, status (block-written): [3:0] head key code, [4] head valid (FIFO non-empty), [11:8] FIFO count, [16] overflow (sticky).
- Word 1, key map (block-written): [15:0] debounced pressed state, bit = row*4+col.
- Word 2, control (software-written): [0] enable, [8] irq_en, [16] clear, [24] pop.
- Block computes an image of all 3 words. It pulses new_data_i whenever the image differs from reg_data_o in word 0/1, or whenever pop or clear is set.
- Control word is written back with pop and clear zeroed, and enable and irq_en copied from reg_data_o.
- Scan timing: ROW_PERIOD = CLK_FREQ*1e6/(SCAN_RATE*4) cycles, generated with simple_timer. The row index 0..3 wraps from 3 to 0.
- FSM IDLE -> SAMPLE -> UPDATE0..UPDATE3 -> IDLE.
  - The timer overflow in IDLE enters SAMPLE, which latches ~cols for the current row and advances the row drive.
  - UPDATEk handles column k of the sampled row:
    - the per-key counter increments while the raw sample differs from the debounced state, and clears when it matches;
    - at DEBOUNCE_SCANS the debounced bit flips and the counter clears;
    - a 0->1 flip pushes code row*4+k.
  - At most one push per cycle, so simultaneous presses in one row queue in ascending column order.
- pop: removes the FIFO head; no effect when empty.
- clear: flushes the FIFO and clears overflow; does not touch the key map.
- FIFO full on push: code dropped, overflow set.
- enable=0:
  - rows=4'b1111, FSM to IDLE, row index 0, timer held in reset;
  - all debounce counters and the key map cleared;
  - FIFO contents kept, and pop and clear still act.

## Timing
- After reset: rows=4'b1111, irq=0, FIFO empty, row index 0, FSM IDLE, all registers 0, so scanning is disabled.
- Row drive changes in the cycle after SAMPLE, leaving a full ROW_PERIOD for column settling before the next sample.
- Push in UPDATEk at cycle t: new_data_i at t+1, status visible on the bus at t+2; irq rises at t+2.
- Pop and push in the same cycle: both happen, count unchanged. On an empty FIFO the pushed code becomes the head.
- Clear and push in the same cycle: clear wins, code dropped, overflow stays 0.
- Clear and pop in the same cycle: clear only.
- If a bus write to word 2 collides with new_data_i, db_reg_intf's bus priority applies. The block re-evaluates the image next cycle, so word 0/1 self-correct.
- enable dropped mid-UPDATE: the FSM aborts the next cycle, and no partial push happens after the abort.
- Key release (1->0 flip) updates word 1 only; nothing is queued.

## Structure
- Shared package (keypad_pkg or config_pkg additions):
  - CFG_BADR_Keypad and CFG_MADR_Keypad;
  - word indices STATUS/KEYMAP/CONTROL;
  - control bit positions;
  - key_code_t = logic [3:0];
  - FSM state enum.
- Sub-module key_fifo:
  - parameter DEPTH;
  - ports: push/pop/clear, data in/out, count, full/empty;
  - synchronous reset; same-cycle push+pop supported when non-empty.
- Reuse simple_timer for the row tick.

## Test plan
Test configuration: CLK_FREQ=1, SCAN_RATE=25000, so ROW_PERIOD=10.
- Reset, read all words -> 0; rows=1111, irq=0.
- Set enable=1 and irq_en=1, then hold col1 low whenever row2 is driven for 4 scans:
  - word1 bit 9 set;
  - word0 = valid=1, code 9, count 1;
  - irq=1.
- Write pop -> count 0, valid 0, irq drops within 3 cycles, control readback shows enable=1, irq_en=1, pop=0.
- Hold a key for only 3 scans with a glitch between -> no queue entry, word1 unchanged.
- Press 9 distinct keys (depth 8) -> count 8, overflow=1, head = first code. Then write clear -> count 0, overflow 0.
- Press cols 0 and 3 of row 1 together -> queue codes 4 then 7 in that order.
- Drop enable mid-scan -> rows=1111 next cycle, word1=0, queued codes retained.
